even_parity_rx: RTL

- Serial receiver that sits directly upstream of the 4-bit even-parity checker.
- Deserialises framed bits into a DATA_W-bit word: start, data LSB first, even-parity bit, stop.
- Flags parity and framing errors and presents the word with a one-cycle valid strobe.
- Bit timing comes from an external sample strobe; no oversampling is done in this block.

---
 rtl/even_parity_pkg.sv | 22 ++
 rtl/even_parity_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial receiver: FSM states,
// line-level constants and the default data width.
`timescale 1ns/1ps
package even_parity_pkg;

    // Default number of data bits per frame.
    localparam int unsigned DATA_W_DEF = 4;

    // Line levels for the start and stop bits.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_e;

endpackage : even_parity_pkg

// File: rtl/even_parity_rx.sv
// Even-parity serial receiver.
// Deserialises frames (start, DATA_W data bits LSB first, even parity, stop)
// sampled on an external bit strobe, and reports each word with a one-cycle
// valid pulse plus parity and framing error flags.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bit_en     - sample strobe; rx only sampled when high
//   rx         - serial line, idle high
//   data       - last received word, held until the next completed frame
//   data_valid - one-cycle pulse when a frame completes
//   parity_err - odd number of ones over data + parity bit of reported frame
//   frame_err  - stop bit of reported frame was sampled low
//   busy       - high from start-bit acceptance until return to IDLE
`timescale 1ns/1ps
module even_parity_rx
    import even_parity_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               acc_q, acc_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               busy_q, busy_d;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath logic; everything holds unless bit_en is high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (rx == START_BIT) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first sample ends up in bit 0.
                    shift_d = (shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
                    acc_d   = acc_q ^ rx;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    acc_d   = acc_q ^ rx;
                    state_d = STOP;
                end
                STOP: begin
                    // Report regardless of errors.
                    data_d  = shift_q;
                    perr_d  = acc_q;
                    ferr_d  = ~rx;
                    valid_d = 1'b1;
                    state_d = (rx == STOP_BIT) ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    // A low line here is a broken stop, never a new start.
                    if (rx == STOP_BIT) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule : even_parity_rx
